// File: rtl/axilite2lb.sv
// AXI4-Lite slave to local-bus bridge.
// The write channel accepts AW and W in either order or together; the read
// channel runs independently. Each local access is bounded by an optional
// timeout that completes the AXI transaction with SLVERR.
module axilite2lb #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int STRB_W  = DATA_W / 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  // AXI write address
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  // AXI write data
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              wvalid,
  output logic              wready,
  // AXI write response
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  // AXI read address
  input  logic [ADDR_W-1:0] araddr,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  // AXI read data
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  // local write port
  output logic [ADDR_W-1:0] lb_waddr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic [STRB_W-1:0] lb_wstrb,
  output logic              lb_wen,
  input  logic              lb_wready,
  // local read port
  output logic [ADDR_W-1:0] lb_raddr,
  output logic              lb_ren,
  input  logic [DATA_W-1:0] lb_rdata,
  input  logic              lb_rvalid
);

  // Local addresses are word aligned: clear the byte-lane bits.
  localparam int LSB_W = $clog2(STRB_W);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~((ADDR_W'(1) << LSB_W) - ADDR_W'(1));

  // Timeout counter sized to hold TIMEOUT; a zero TIMEOUT disables the check.
  localparam int CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
  localparam bit TO_EN = (TIMEOUT > 0);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_EXEC, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_EXEC, R_RESP} rstate_t;

  wstate_t wstate_reg, wstate_next;
  rstate_t rstate_reg, rstate_next;

  logic [ADDR_W-1:0] waddr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [STRB_W-1:0] wstrb_reg;
  logic [1:0]        bresp_reg;
  logic [CNT_W-1:0]  wcnt_reg;

  logic [ADDR_W-1:0] raddr_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic [1:0]        rresp_reg;
  logic [CNT_W-1:0]  rcnt_reg;

  logic w_timeout;
  logic r_timeout;

  // Protection bits carry no meaning for the local bus.
  logic unused_prot;
  assign unused_prot = ^{awprot, arprot};

  // Timeout fires on the last permitted EXEC cycle; an ack in that cycle takes priority.
  assign w_timeout = TO_EN && (wcnt_reg == TO_LAST);
  assign r_timeout = TO_EN && (rcnt_reg == TO_LAST);

  assign lb_waddr = waddr_reg;
  assign lb_wdata = wdata_reg;
  assign lb_wstrb = wstrb_reg;
  assign bresp    = bresp_reg;
  assign lb_raddr = raddr_reg;
  assign rdata    = rdata_reg;
  assign rresp    = rresp_reg;

  // ---------------- write channel ----------------

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (rst) wstate_reg <= W_IDLE;
    else     wstate_reg <= wstate_next;
  end

  // Write FSM next state: collect AW and W in any order, execute, respond.
  always_comb begin
    wstate_next = wstate_reg;
    case (wstate_reg)
      W_IDLE: begin
        if (awvalid && wvalid) wstate_next = W_EXEC;
        else if (awvalid)      wstate_next = W_ADDR;
        else if (wvalid)       wstate_next = W_DATA;
      end
      W_ADDR:  if (wvalid)                 wstate_next = W_EXEC;
      W_DATA:  if (awvalid)                wstate_next = W_EXEC;
      W_EXEC:  if (lb_wready || w_timeout) wstate_next = W_RESP;
      W_RESP:  if (bready)                 wstate_next = W_IDLE;
      default: wstate_next = W_IDLE;
    endcase
  end

  // Write FSM outputs; readies are held low while reset is applied.
  always_comb begin
    awready = !rst && ((wstate_reg == W_IDLE) || (wstate_reg == W_DATA));
    wready  = !rst && ((wstate_reg == W_IDLE) || (wstate_reg == W_ADDR));
    lb_wen  = (wstate_reg == W_EXEC);
    bvalid  = (wstate_reg == W_RESP);
  end

  // Write datapath: capture address/data at their handshakes, count EXEC cycles, latch response.
  always_ff @(posedge clk) begin
    if (rst) begin
      waddr_reg <= '0;
      wdata_reg <= '0;
      wstrb_reg <= '0;
      bresp_reg <= RESP_OKAY;
      wcnt_reg  <= '0;
    end else begin
      if (awvalid && awready) waddr_reg <= awaddr & ADDR_MASK;
      if (wvalid && wready) begin
        wdata_reg <= wdata;
        wstrb_reg <= wstrb;
      end
      if (wstate_reg == W_EXEC) begin
        wcnt_reg <= wcnt_reg + CNT_W'(1);
        if (lb_wready)      bresp_reg <= RESP_OKAY;
        else if (w_timeout) bresp_reg <= RESP_SLVERR;
      end else begin
        wcnt_reg <= '0;
      end
    end
  end

  // ---------------- read channel ----------------

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (rst) rstate_reg <= R_IDLE;
    else     rstate_reg <= rstate_next;
  end

  // Read FSM next state: accept address, wait for local data or timeout, respond.
  always_comb begin
    rstate_next = rstate_reg;
    case (rstate_reg)
      R_IDLE:  if (arvalid)                rstate_next = R_EXEC;
      R_EXEC:  if (lb_rvalid || r_timeout) rstate_next = R_RESP;
      R_RESP:  if (rready)                 rstate_next = R_IDLE;
      default: rstate_next = R_IDLE;
    endcase
  end

  // Read FSM outputs.
  always_comb begin
    arready = !rst && (rstate_reg == R_IDLE);
    lb_ren  = (rstate_reg == R_EXEC);
    rvalid  = (rstate_reg == R_RESP);
  end

  // Read datapath: capture address, count EXEC cycles, latch data and response.
  always_ff @(posedge clk) begin
    if (rst) begin
      raddr_reg <= '0;
      rdata_reg <= '0;
      rresp_reg <= RESP_OKAY;
      rcnt_reg  <= '0;
    end else begin
      if (arvalid && arready) raddr_reg <= araddr & ADDR_MASK;
      if (rstate_reg == R_EXEC) begin
        rcnt_reg <= rcnt_reg + CNT_W'(1);
        if (lb_rvalid) begin
          rdata_reg <= lb_rdata;
          rresp_reg <= RESP_OKAY;
        end else if (r_timeout) begin
          rdata_reg <= '0;
          rresp_reg <= RESP_SLVERR;
        end
      end else begin
        rcnt_reg <= '0;
      end
    end
  end

endmodule
